// File: rtl/mont_encode.sv
// mont_encode: streaming normal->Montgomery converter, out = a*2^16 mod q; define MONT_ENCODE_CANON_EN for canonical [0,q-1] output (LAT=4)
module mont_encode #(
  parameter int KYBER_Q = 3329,
  parameter int QINV    = -3327,
  parameter int MONT_F  = 1353,
  parameter int N       = 256,
  parameter int WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [$clog2(N)-1:0]    out_idx,
  output logic                    out_last
);
  localparam int IW = $clog2(N);
  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] F  = PW'(MONT_F);
  localparam logic signed [PW-1:0] QI = PW'(QINV);
  localparam logic signed [PW-1:0] Q  = PW'(KYBER_Q);

  logic                    adv;
  logic [IW-1:0]           cnt, idx1, idx2, oi;
  logic                    v1, v2, ov;
  logic signed [PW-1:0]    p0, p1, p2;
  logic signed [WIDTH-1:0] t2, r, od;

  // the whole pipeline moves together whenever the output slot is free or being drained
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign p0       = PW'(in_data) * F;
  // p - t*q has its low half cleared by construction, so the high half is the reduced value
  assign r        = WIDTH'((p2 - PW'(t2) * Q) >>> WIDTH);

  // input index counter, advanced on every accepted coefficient
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (in_valid & adv) cnt <= (cnt == IW'(N - 1)) ? '0 : cnt + 1'b1;

  // S1 forms a*F, S2 forms the Montgomery quotient t; valid and index ride along
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1   <= 1'b0;
      p1   <= '0;
      idx1 <= '0;
      v2   <= 1'b0;
      p2   <= '0;
      t2   <= '0;
      idx2 <= '0;
    end else if (adv) begin
      v1   <= in_valid;
      p1   <= p0;
      idx1 <= cnt;
      v2   <= v1;
      p2   <= p1;
      t2   <= WIDTH'(p1 * QI);
      idx2 <= idx1;
    end

`ifdef MONT_ENCODE_CANON_EN
  logic                    v3;
  logic signed [WIDTH-1:0] r3;
  logic [IW-1:0]           idx3;

  // extra stage holding the centred result before it is folded into [0, q-1]
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v3   <= 1'b0;
      r3   <= '0;
      idx3 <= '0;
    end else if (adv) begin
      v3   <= v2;
      r3   <= r;
      idx3 <= idx2;
    end

  assign ov = v3;
  assign od = (r3 < 0) ? r3 + WIDTH'(KYBER_Q) : r3;
  assign oi = idx3;
`else
  assign ov = v2;
  assign od = r;
  assign oi = idx2;
`endif

  // output register, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (adv) begin
      out_valid <= ov;
      out_data  <= od;
      out_idx   <= oi;
      out_last  <= (oi == IW'(N - 1));
    end
endmodule
